// File: rtl/tanimoto_ctrl_pkg.sv
// Shared types for the tanimoto job controller.
// Holds the FSM state encoding and the pair-counter width.
package tanimoto_ctrl_pkg;

  localparam int PAIR_CNT_WIDTH = 32;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_CMPNO  = 3'd2,
    S_STREAM = 3'd3,
    S_DRAIN  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

endpackage

// File: rtl/tanimoto_job_ctrl_axis_beat_gate.sv
// Input-beat admission gate: counts down admitted beats.
// Ports: load/count, gate enable, src valid/ready, core valid/read, last-beat pulse.
module axis_beat_gate #(
  parameter int BEAT_CNT_WIDTH = 32
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst,
  input  logic                      i_Load,
  input  logic [BEAT_CNT_WIDTH-1:0] i_LoadCount,
  input  logic                      i_Gate,
  input  logic                      i_Src_Valid,
  input  logic                      i_Core_Read,
  output logic                      o_Src_Ready,
  output logic                      o_Core_Valid,
  output logic                      o_LastBeat,
  output logic                      o_Zero
);

  logic [BEAT_CNT_WIDTH-1:0] beats_left;
  logic                      fire;

  assign o_Src_Ready  = i_Core_Read & i_Gate;
  assign o_Core_Valid = i_Src_Valid & i_Gate;
  assign fire         = i_Src_Valid & i_Core_Read & i_Gate;
  assign o_LastBeat   = fire & (beats_left == BEAT_CNT_WIDTH'(1));
  assign o_Zero       = (beats_left == '0);

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      beats_left <= '0;
    end else if (i_Load) begin
      beats_left <= i_LoadCount;
    end else if (fire && !o_Zero) begin
      beats_left <= beats_left - BEAT_CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/tanimoto_job_ctrl.sv
// Job sequencer: threshold BRAM load, CmpVectorNo handshake,
// beat-limited input admission and final ID-pair drain.
// Ports: host start/done/busy, THR stream, BRAM port, CmpVectorNo
// handshake, input-stream gating, ID-pair stream taps.
module tanimoto_job_ctrl
  import tanimoto_ctrl_pkg::*;
#(
  parameter int BUS_WIDTH      = 512,
  parameter int VECTOR_WIDTH   = 920,
  parameter int VEC_ID_WIDTH   = 8,
  parameter int CNT_WIDTH      = $clog2(VECTOR_WIDTH),
  parameter int THR_DEPTH      = VECTOR_WIDTH,
  parameter int BEAT_CNT_WIDTH = 32
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst,
  input  logic                      i_Start,
  input  logic [VEC_ID_WIDTH-1:0]   i_CmpVectorNo,
  input  logic [BEAT_CNT_WIDTH-1:0] i_BeatCount,
  output logic                      o_Busy,
  output logic                      o_Done,
  output logic [PAIR_CNT_WIDTH-1:0] o_PairCount,
  input  logic [CNT_WIDTH-1:0]      S_AXIS_THR_tdata,
  input  logic                      S_AXIS_THR_tvalid,
  output logic                      S_AXIS_THR_tready,
  output logic [CNT_WIDTH-1:0]      o_BRAM_Addr,
  output logic [CNT_WIDTH-1:0]      o_BRAM_Din,
  output logic                      o_BRAM_En,
  output logic                      o_BRAM_WrEn,
  output logic [VEC_ID_WIDTH-1:0]   o_CmpVectorNo,
  output logic                      o_CmpVectorNoValid,
  input  logic                      i_CmpVectorNoWack,
  input  logic                      i_Src_Valid,
  output logic                      o_Src_Ready,
  output logic                      o_Core_Valid,
  input  logic                      i_Core_Read,
  input  logic                      i_Pair_Valid,
  input  logic                      i_Pair_Ready,
  input  logic                      i_Pair_Last
);

  state_t               state;
  logic [CNT_WIDTH-1:0] thr_addr;
  logic                 last_seen;
  logic                 thr_hs;
  logic                 pair_hs;
  logic                 tlast_hs;
  logic                 start_hs;
  logic                 gate;
  logic                 last_beat;
  logic                 beat_zero;

  assign thr_hs   = S_AXIS_THR_tready & S_AXIS_THR_tvalid;
  assign pair_hs  = i_Pair_Valid & i_Pair_Ready;
  assign tlast_hs = pair_hs & i_Pair_Last;
  assign start_hs = (state == S_IDLE) & i_Start;
  assign gate     = (state == S_STREAM);

  axis_beat_gate #(
    .BEAT_CNT_WIDTH(BEAT_CNT_WIDTH)
  ) u_gate (
    .ap_clk      (ap_clk),
    .ap_rst      (ap_rst),
    .i_Load      (start_hs),
    .i_LoadCount (i_BeatCount),
    .i_Gate      (gate),
    .i_Src_Valid (i_Src_Valid),
    .i_Core_Read (i_Core_Read),
    .o_Src_Ready (o_Src_Ready),
    .o_Core_Valid(o_Core_Valid),
    .o_LastBeat  (last_beat),
    .o_Zero      (beat_zero)
  );

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state              <= S_IDLE;
      thr_addr           <= '0;
      last_seen          <= 1'b0;
      o_Busy             <= 1'b0;
      o_Done             <= 1'b0;
      o_PairCount        <= '0;
      S_AXIS_THR_tready  <= 1'b0;
      o_BRAM_Addr        <= '0;
      o_BRAM_Din         <= '0;
      o_BRAM_En          <= 1'b0;
      o_BRAM_WrEn        <= 1'b0;
      o_CmpVectorNo      <= '0;
      o_CmpVectorNoValid <= 1'b0;
    end else begin
      o_BRAM_En   <= 1'b0;
      o_BRAM_WrEn <= 1'b0;
      if (o_Busy && pair_hs && (o_PairCount != '1))
        o_PairCount <= o_PairCount + PAIR_CNT_WIDTH'(1);
      if (o_Busy && tlast_hs)
        last_seen <= 1'b1;
      unique case (state)
        S_IDLE: begin
          if (i_Start) begin
            state             <= S_LOAD;
            o_Busy            <= 1'b1;
            S_AXIS_THR_tready <= 1'b1;
            o_CmpVectorNo     <= i_CmpVectorNo;
            o_PairCount       <= '0;
            last_seen         <= 1'b0;
            thr_addr          <= '0;
          end
        end
        S_LOAD: begin
          if (thr_hs) begin
            o_BRAM_En   <= 1'b1;
            o_BRAM_WrEn <= 1'b1;
            o_BRAM_Addr <= thr_addr;
            o_BRAM_Din  <= S_AXIS_THR_tdata;
            thr_addr    <= thr_addr + CNT_WIDTH'(1);
            if (thr_addr == CNT_WIDTH'(THR_DEPTH - 1)) begin
              state              <= S_CMPNO;
              S_AXIS_THR_tready  <= 1'b0;
              o_CmpVectorNoValid <= 1'b1;
            end
          end
        end
        S_CMPNO: begin
          if (i_CmpVectorNoWack) begin
            o_CmpVectorNoValid <= 1'b0;
            state <= beat_zero ? S_DRAIN : S_STREAM;
          end
        end
        S_STREAM: begin
          // a tlast landing with the final beat counts as already seen
          if (last_beat) begin
            if (last_seen || tlast_hs) begin
              state  <= S_DONE;
              o_Done <= 1'b1;
            end else begin
              state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (tlast_hs) begin
            state  <= S_DONE;
            o_Done <= 1'b1;
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          o_Done <= 1'b0;
          o_Busy <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tanimoto_job_ctrl.sv
// Directed bench for tanimoto_job_ctrl with a 4-entry threshold table.
// Cycle tables cover full jobs; hand sequences cover async reset.
module tb_tanimoto_job_ctrl;

  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b1;
  logic        i_Start = 0;
  logic [7:0]  i_CmpVectorNo = '0;
  logic [31:0] i_BeatCount = '0;
  logic        o_Busy, o_Done;
  logic [31:0] o_PairCount;
  logic [9:0]  thr_tdata = '0;
  logic        thr_tvalid = 0;
  logic        thr_tready;
  logic [9:0]  o_BRAM_Addr, o_BRAM_Din;
  logic        o_BRAM_En, o_BRAM_WrEn;
  logic [7:0]  o_CmpVectorNo;
  logic        o_CmpVectorNoValid;
  logic        i_CmpVectorNoWack = 0;
  logic        i_Src_Valid = 0;
  logic        o_Src_Ready, o_Core_Valid;
  logic        i_Core_Read = 0;
  logic        i_Pair_Valid = 0;
  logic        i_Pair_Ready = 1;
  logic        i_Pair_Last = 0;

  always #5 ap_clk = ~ap_clk;

  tanimoto_job_ctrl #(
    .THR_DEPTH(4)
  ) dut (
    .ap_clk            (ap_clk),
    .ap_rst            (ap_rst),
    .i_Start           (i_Start),
    .i_CmpVectorNo     (i_CmpVectorNo),
    .i_BeatCount       (i_BeatCount),
    .o_Busy            (o_Busy),
    .o_Done            (o_Done),
    .o_PairCount       (o_PairCount),
    .S_AXIS_THR_tdata  (thr_tdata),
    .S_AXIS_THR_tvalid (thr_tvalid),
    .S_AXIS_THR_tready (thr_tready),
    .o_BRAM_Addr       (o_BRAM_Addr),
    .o_BRAM_Din        (o_BRAM_Din),
    .o_BRAM_En         (o_BRAM_En),
    .o_BRAM_WrEn       (o_BRAM_WrEn),
    .o_CmpVectorNo     (o_CmpVectorNo),
    .o_CmpVectorNoValid(o_CmpVectorNoValid),
    .i_CmpVectorNoWack (i_CmpVectorNoWack),
    .i_Src_Valid       (i_Src_Valid),
    .o_Src_Ready       (o_Src_Ready),
    .o_Core_Valid      (o_Core_Valid),
    .i_Core_Read       (i_Core_Read),
    .i_Pair_Valid      (i_Pair_Valid),
    .i_Pair_Ready      (i_Pair_Ready),
    .i_Pair_Last       (i_Pair_Last)
  );

  typedef struct packed {
    logic        busy, done, tr, en, wr;
    logic [9:0]  ad, di;
    logic        cv;
    logic [7:0]  cno;
    logic        sr, co;
    logic [31:0] pc;
  } out_t;

  typedef struct {
    logic        st;
    logic [31:0] bc;
    logic [7:0]  cn;
    logic        tv;
    logic [9:0]  td;
    logic        wk, sv, cr, pv, pl;
    out_t        exp;
  } vec_t;

  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;

  task automatic add(
    input logic st, input int bc, input logic [7:0] cn,
    input logic tv, input logic [9:0] td,
    input logic wk, sv, cr, pv, pl,
    input logic bz, dn, tr, en,
    input logic [9:0] ad, di,
    input logic cv, input logic [7:0] ce,
    input logic sr, co, input int pc);
    vec_t v;
    v.st = st; v.bc = bc; v.cn = cn; v.tv = tv; v.td = td;
    v.wk = wk; v.sv = sv; v.cr = cr; v.pv = pv; v.pl = pl;
    v.exp = '{busy: bz, done: dn, tr: tr, en: en, wr: en,
              ad: ad, di: di, cv: cv, cno: ce,
              sr: sr, co: co, pc: pc};
    tbl.push_back(v);
  endtask

  function automatic out_t sample();
    out_t s;
    s.busy = o_Busy;
    s.done = o_Done;
    s.tr   = thr_tready;
    s.en   = o_BRAM_En;
    s.wr   = o_BRAM_WrEn;
    s.ad   = o_BRAM_En ? o_BRAM_Addr : 10'd0;
    s.di   = o_BRAM_En ? o_BRAM_Din : 10'd0;
    s.cv   = o_CmpVectorNoValid;
    s.cno  = o_CmpVectorNoValid ? o_CmpVectorNo : 8'd0;
    s.sr   = o_Src_Ready;
    s.co   = o_Core_Valid;
    s.pc   = o_PairCount;
    return s;
  endfunction

  task automatic check(input string name, input out_t got, input out_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    i_Start = v.st; i_BeatCount = v.bc; i_CmpVectorNo = v.cn;
    thr_tvalid = v.tv; thr_tdata = v.td;
    i_CmpVectorNoWack = v.wk;
    i_Src_Valid = v.sv; i_Core_Read = v.cr;
    i_Pair_Valid = v.pv; i_Pair_Last = v.pl;
  endtask

  initial begin
    out_t e;
    // job A: 4 thresholds, 3 beats, src held valid, late Wack
    add(1,3,8'h2A,0,0,0,1,1,0,0, 0,0,0,0,0,0,0,0,0,0,0);
    add(0,0,0,1,5,0,1,1,0,0, 1,0,1,0,0,0,0,0,0,0,0);
    add(0,0,0,1,6,0,1,1,0,0, 1,0,1,1,0,5,0,0,0,0,0);
    add(0,0,0,1,7,0,1,1,0,0, 1,0,1,1,1,6,0,0,0,0,0);
    add(0,0,0,1,8,0,1,1,0,0, 1,0,1,1,2,7,0,0,0,0,0);
    add(0,0,0,1,9,0,1,1,0,0, 1,0,0,1,3,8,1,8'h2A,0,0,0);
    add(0,0,0,0,0,1,1,1,0,0, 1,0,0,0,0,0,1,8'h2A,0,0,0);
    add(0,0,0,0,0,0,1,1,0,0, 1,0,0,0,0,0,0,0,1,1,0);
    add(0,0,0,0,0,0,1,0,0,0, 1,0,0,0,0,0,0,0,0,1,0);
    add(0,0,0,0,0,0,1,1,1,0, 1,0,0,0,0,0,0,0,1,1,0);
    add(1,7,8'h11,0,0,0,1,1,0,0, 1,0,0,0,0,0,0,0,1,1,1);
    add(0,0,0,0,0,0,1,1,1,0, 1,0,0,0,0,0,0,0,0,0,1);
    add(0,0,0,0,0,0,1,1,1,1, 1,0,0,0,0,0,0,0,0,0,2);
    add(0,0,0,0,0,0,0,0,0,0, 1,1,0,0,0,0,0,0,0,0,3);
    add(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0,3);
    // job B: zero beats, toggling THR valid, immediate Wack
    add(1,0,8'h07,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0,3);
    add(0,0,0,1,10'h11,0,0,0,0,0, 1,0,1,0,0,0,0,0,0,0,0);
    add(0,0,0,0,0,0,0,0,0,0, 1,0,1,1,0,10'h11,0,0,0,0,0);
    add(0,0,0,1,10'h12,0,0,0,0,0, 1,0,1,0,0,0,0,0,0,0,0);
    add(0,0,0,0,0,0,0,0,0,0, 1,0,1,1,1,10'h12,0,0,0,0,0);
    add(0,0,0,1,10'h13,0,0,0,0,0, 1,0,1,0,0,0,0,0,0,0,0);
    add(0,0,0,0,0,0,0,0,0,0, 1,0,1,1,2,10'h13,0,0,0,0,0);
    add(0,0,0,1,10'h14,0,0,0,0,0, 1,0,1,0,0,0,0,0,0,0,0);
    add(0,0,0,0,0,1,0,0,0,0, 1,0,0,1,3,10'h14,1,8'h07,0,0,0);
    add(0,0,0,0,0,0,1,1,1,1, 1,0,0,0,0,0,0,0,0,0,0);
    add(0,0,0,0,0,0,0,0,0,0, 1,1,0,0,0,0,0,0,0,0,1);
    add(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0,1);
    // job C: Wack after 5 valid cycles, tlast seen during STREAM
    add(1,2,8'h55,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0,1);
    add(0,0,0,1,1,0,0,0,0,0, 1,0,1,0,0,0,0,0,0,0,0);
    add(0,0,0,1,2,0,0,0,0,0, 1,0,1,1,0,1,0,0,0,0,0);
    add(0,0,0,1,3,0,0,0,0,0, 1,0,1,1,1,2,0,0,0,0,0);
    add(0,0,0,1,4,0,0,0,0,0, 1,0,1,1,2,3,0,0,0,0,0);
    add(0,0,0,0,0,0,0,0,0,0, 1,0,0,1,3,4,1,8'h55,0,0,0);
    add(0,0,0,0,0,0,0,0,0,0, 1,0,0,0,0,0,1,8'h55,0,0,0);
    add(0,0,0,0,0,0,0,0,0,0, 1,0,0,0,0,0,1,8'h55,0,0,0);
    add(0,0,0,0,0,0,0,0,0,0, 1,0,0,0,0,0,1,8'h55,0,0,0);
    add(0,0,0,0,0,1,0,0,0,0, 1,0,0,0,0,0,1,8'h55,0,0,0);
    add(0,0,0,0,0,0,1,1,1,1, 1,0,0,0,0,0,0,0,1,1,0);
    add(0,0,0,0,0,0,1,1,0,0, 1,0,0,0,0,0,0,0,1,1,1);
    add(0,0,0,0,0,0,1,1,0,0, 1,1,0,0,0,0,0,0,0,0,1);
    add(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0,1);

    repeat (2) @(negedge ap_clk);
    #2 check("reset_hold", sample(), '0);
    ap_rst = 1'b0;
    @(negedge ap_clk);
    #2 check("reset_state", sample(), '0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge ap_clk);
      drive(tbl[i]);
      #2 check($sformatf("row%0d", i), sample(), tbl[i].exp);
    end

    // async reset with a BRAM write in flight
    @(negedge ap_clk);
    i_Start = 1; i_BeatCount = 5; i_CmpVectorNo = 8'h03;
    @(negedge ap_clk);
    i_Start = 0; thr_tvalid = 1; thr_tdata = 10'd21;
    @(negedge ap_clk);
    thr_tdata = 10'd22;
    @(negedge ap_clk);
    thr_tvalid = 0;
    e = '0; e.busy = 1; e.tr = 1; e.en = 1; e.wr = 1;
    e.ad = 10'd1; e.di = 10'd22;
    #2 check("pre_reset_write", sample(), e);
    ap_rst = 1'b1;
    #1 check("async_reset", sample(), '0);
    #1 ap_rst = 1'b0;

    // restart must begin at address 0
    @(negedge ap_clk);
    i_Start = 1; i_BeatCount = 1;
    @(negedge ap_clk);
    i_Start = 0; thr_tvalid = 1; thr_tdata = 10'd33;
    @(negedge ap_clk);
    thr_tvalid = 0;
    e = '0; e.busy = 1; e.tr = 1; e.en = 1; e.wr = 1;
    e.ad = 10'd0; e.di = 10'd33;
    #2 check("restart_addr0", sample(), e);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tanimoto_job_ctrl.md
# tanimoto_job_ctrl

Job-level sequencer for the tanimoto accelerator pipeline. On a host start pulse it loads the comparator threshold BRAM from a stream, then performs the compare-vector-number handshake. It then admits exactly the requested number of input-vector beats into the pipeline and waits for the final ID pair before signalling done. It sits between the host/DMA side and the pipeline top, driving its BRAM port and CmpVectorNo handshake and gating its input-stream valid/ready.

## Interface
- Clocking: one clock `ap_clk`; reset `ap_rst` is asynchronous, active-high. BRAM clock is tied to `ap_clk` externally.

Parameters:
- BUS_WIDTH, 512, input stream width (gating only, data not routed here)
- VECTOR_WIDTH, 920, fingerprint bit count
- VEC_ID_WIDTH, 8, vector ID width
- CNT_WIDTH, $clog2(VECTOR_WIDTH), BRAM address/data width
- THR_DEPTH, VECTOR_WIDTH, threshold entries loaded per job (addresses 0..THR_DEPTH-1)
- BEAT_CNT_WIDTH, 32, input beat counter width

Ports:
- ap_clk  in  1  clock
- ap_rst  in  1  async active-high reset
- i_Start  in  1  job start pulse, sampled in IDLE only
- i_CmpVectorNo  in  VEC_ID_WIDTH  job compare-vector count, captured at start
- i_BeatCount  in  BEAT_CNT_WIDTH  input beats to admit, captured at start
- o_Busy  out  1  high in every state except IDLE
- o_Done  out  1  one-cycle pulse at job end
- o_PairCount  out  32  ID pairs handshaken this job, saturating
- S_AXIS_THR_tdata  in  CNT_WIDTH  threshold entry
- S_AXIS_THR_tvalid  in  1
- S_AXIS_THR_tready  out  1  high only in LOAD
- o_BRAM_Addr  out  CNT_WIDTH
- o_BRAM_Din  out  CNT_WIDTH
- o_BRAM_En  out  1
- o_BRAM_WrEn  out  1
- o_CmpVectorNo  out  VEC_ID_WIDTH
- o_CmpVectorNoValid  out  1
- i_CmpVectorNoWack  in  1
- i_Src_Valid  in  1  upstream tvalid
- o_Src_Ready  out  1  upstream tready = i_Core_Read & gate
- o_Core_Valid  out  1  pipeline i_Valid = i_Src_Valid & gate
- i_Core_Read  in  1  pipeline o_Read
- i_Pair_Valid, i_Pair_Ready, i_Pair_Last  in  1 each  taps of the ID-pair output stream (observe only)

## Operation
- States: IDLE, LOAD, CMPNO, STREAM, DRAIN, DONE.
- IDLE: on i_Start, capture i_CmpVectorNo, i_BeatCount, clear o_PairCount and last-seen flag, go to LOAD.
- LOAD: tready=1. Each THR handshake k writes Din=tdata at Addr=k. After the THR_DEPTH-th handshake, go to CMPNO.
- CMPNO: o_CmpVectorNoValid=1 with captured value. On i_CmpVectorNoWack, go to STREAM, or to DRAIN if the beat count is 0.
- STREAM: gate=1. The beat counter decrements on each i_Src_Valid & i_Core_Read. On the last beat, go to DRAIN, or to DONE if the last-seen flag is already set.
- DRAIN: wait for i_Pair_Valid & i_Pair_Ready & i_Pair_Last, then go to DONE.
- DONE: o_Done=1 for one cycle, then IDLE.
- Pair counting: o_PairCount increments on every pair handshake while Busy and saturates at 2^32-1. A tlast handshake in any busy state sets the last-seen flag.
- i_Start outside IDLE is ignored. THR beats outside LOAD are not accepted.

## Timing
- Reset values: all outputs 0; state IDLE; counters and flag 0.
- i_Start at cycle t: o_Busy=1 and S_AXIS_THR_tready=1 at t+1.
- BRAM write outputs are registered. A handshake at cycle c gives En=WrEn=1 with Addr/Din at c+1; En/WrEn are 0 otherwise.
- o_CmpVectorNoValid rises the cycle after the final BRAM write is issued. It holds until Wack and is 0 the cycle after. Wack in the first valid cycle is legal.
- Gating is combinational from state. No beat beyond i_BeatCount reaches the pipeline: gate drops in the cycle after the last handshake.
- Done pulse occurs 1 cycle after the DRAIN tlast handshake. o_Busy falls together with the Done pulse's end.
- Reset mid-job aborts immediately. Any in-flight BRAM write is dropped and the handshake valid is deasserted.

## Structure
- Package `tanimoto_ctrl_pkg`: state enum encoding and the pair-counter width constant.
- One natural sub-module: `axis_beat_gate`, holding the beat down-counter plus valid/ready gating and producing a last-beat pulse.
- Everything else stays in the FSM file.

## Test plan
- THR_DEPTH=4, BeatCount=3, thresholds 5,6,7,8 -> BRAM writes (0,5)(1,6)(2,7)(3,8), then CmpVectorNo handshake, exactly 3 beats admitted, tlast pair -> o_Done, PairCount as sent.
- Upstream valid held high during LOAD/CMPNO -> o_Core_Valid=0 and o_Src_Ready=0 until STREAM. After the 3rd beat, valid stays gated off.
- Wack delayed 5 cycles -> valid held 5 cycles with a stable value. Wack in the first cycle -> one-cycle valid.
- BeatCount=0 -> CMPNO goes straight to DRAIN. tlast during STREAM -> DONE right after the final beat, skipping DRAIN.
- i_Start during STREAM -> ignored. ap_rst asserted mid-LOAD -> all outputs 0 asynchronously, next i_Start restarts at Addr 0.
- THR tvalid toggling 1,0,1,0 -> writes only on handshake cycles, addresses contiguous.
